// File: rtl/spi_slave_core.sv
// SPI responder in the PCLK domain: oversamples SCLK/SS/MOSI, receives one byte per
// eight sample edges and shifts a buffered byte out on MISO. FSM: IDLE (deselected), SHIFT (selected).
module spi_slave_core (
  input  logic       PCLK,
  input  logic       PRESET_n,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       lsbfe_i,
  input  logic       ss_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_en_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_load_i,
  output logic       tx_empty_o,
  output logic       tx_underrun_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t     state;
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       ss_s1, ss_s2, ss_s3;
  logic       mosi_s1, mosi_s2;
  logic       cpol_q, cpha_q, lsbfe_q;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr, tx_sr, tx_buf;

  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic       lead_edge, trail_edge, sample_edge, shift_edge;
  logic [7:0] rx_next, start_byte, start_shifted, tx_adv;
  logic       start_cpha, start_lsbfe, start_first, tx_head, byte_start;

  // ss synchronizer idles high so a deselected bus never looks like a falling edge
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_s3   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk_i;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ss_s1   <= ss_i;
      ss_s2   <= ss_s1;
      ss_s3   <= ss_s2;
      mosi_s1 <= mosi_i;
      mosi_s2 <= mosi_s1;
    end
  end

  always_comb begin
    sclk_rise   = sclk_s2 & ~sclk_s3;
    sclk_fall   = ~sclk_s2 & sclk_s3;
    ss_fall     = ~ss_s2 & ss_s3;
    ss_rise     = ss_s2 & ~ss_s3;
    lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    sample_edge = cpha_q ? trail_edge : lead_edge;
    shift_edge  = cpha_q ? lead_edge : trail_edge;
    rx_next     = lsbfe_q ? {mosi_s2, rx_sr[7:1]} : {rx_sr[6:0], mosi_s2};
    tx_head     = lsbfe_q ? tx_sr[0] : tx_sr[7];
    tx_adv      = lsbfe_q ? {1'b0, tx_sr[7:1]} : {tx_sr[6:0], 1'b0};
    // At SHIFT entry the mode registers are not yet loaded, so use the live inputs
    start_cpha    = (state == IDLE) ? cpha_i : cpha_q;
    start_lsbfe   = (state == IDLE) ? lsbfe_i : lsbfe_q;
    start_byte    = tx_empty_o ? 8'h00 : tx_buf;
    start_first   = start_lsbfe ? start_byte[0] : start_byte[7];
    start_shifted = start_lsbfe ? {1'b0, start_byte[7:1]} : {start_byte[6:0], 1'b0};
    byte_start    = ((state == IDLE) && ss_fall) ||
                    ((state == SHIFT) && !ss_rise && sample_edge && (bit_cnt == 3'd7));
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state         <= IDLE;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      lsbfe_q       <= 1'b0;
      bit_cnt       <= 3'd0;
      rx_sr         <= 8'h00;
      tx_sr         <= 8'h00;
      tx_buf        <= 8'h00;
      miso_o        <= 1'b0;
      miso_en_o     <= 1'b0;
      tx_empty_o    <= 1'b1;
      tx_underrun_o <= 1'b0;
      rx_data_o     <= 8'h00;
      rx_valid_o    <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;

      case (state)
        IDLE: begin
          bit_cnt   <= 3'd0;
          miso_o    <= 1'b0;
          miso_en_o <= 1'b0;
          busy_o    <= 1'b0;
          if (ss_fall) begin
            state     <= SHIFT;
            busy_o    <= 1'b1;
            miso_en_o <= 1'b1;
            cpol_q    <= cpol_i;
            cpha_q    <= cpha_i;
            lsbfe_q   <= lsbfe_i;
            rx_sr     <= 8'h00;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            miso_en_o <= 1'b0;
            miso_o    <= 1'b0;
            bit_cnt   <= 3'd0;
            rx_sr     <= 8'h00;
            tx_sr     <= 8'h00;
          end else if (sample_edge) begin
            rx_sr   <= rx_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_o  <= rx_next;
              rx_valid_o <= 1'b1;
            end
          end else if (shift_edge && (cpha_q || (bit_cnt != 3'd0))) begin
            // cpha=0: the shift edge right after the 8th sample is skipped, the next
            // byte's first bit was already driven at byte start
            miso_o <= tx_head;
            tx_sr  <= tx_adv;
          end
        end
        default: state <= IDLE;
      endcase

      if (byte_start) begin
        tx_sr <= start_cpha ? start_byte : start_shifted;
        if (!start_cpha)
          miso_o <= start_first;
        if (tx_empty_o)
          tx_underrun_o <= 1'b1;
        else
          tx_empty_o <= 1'b1;
      end

      if (tx_load_i) begin
        tx_buf     <= tx_data_i;
        tx_empty_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a behavioural SPI master drives the bus in all four
// modes and compares received bytes and status outputs against hand-computed values.
module tb_spi_slave_core;

  logic       PCLK;
  logic       PRESET_n;
  logic       cpol, cpha, lsbfe;
  logic       ss, sclk, mosi;
  logic       miso_o, miso_en_o;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_empty_o, tx_underrun_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, busy_o;

  int errors = 0;
  int checks = 0;
  int rv_cnt = 0;
  int ur_cnt = 0;

  spi_slave_core dut (
    .PCLK          (PCLK),
    .PRESET_n      (PRESET_n),
    .cpol_i        (cpol),
    .cpha_i        (cpha),
    .lsbfe_i       (lsbfe),
    .ss_i          (ss),
    .sclk_i        (sclk),
    .mosi_i        (mosi),
    .miso_o        (miso_o),
    .miso_en_o     (miso_en_o),
    .tx_data_i     (tx_data),
    .tx_load_i     (tx_load),
    .tx_empty_o    (tx_empty_o),
    .tx_underrun_o (tx_underrun_o),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .busy_o        (busy_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // pulse counters, sampled mid-cycle
  always @(negedge PCLK) begin
    if (rx_valid_o === 1'b1) rv_cnt++;
    if (tx_underrun_o === 1'b1) ur_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic half();
    wait_cyc(8);
  endtask

  task automatic load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge PCLK);
    tx_load = 1'b0;
  endtask

  // one master byte; optional buffer load during bit 3
  task automatic xfer(input logic [7:0] tx_b, output logic [7:0] rx_b, input int nbits,
                      input bit do_load, input logic [7:0] load_val);
    int idx;
    rx_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = lsbfe ? i : 7 - i;
      if (do_load && i == 3) load(load_val);
      if (!cpha) mosi = tx_b[idx];
      half();
      sclk = ~cpol;
      if (!cpha) rx_b[idx] = miso_o;
      else mosi = tx_b[idx];
      half();
      sclk = cpol;
      if (cpha) rx_b[idx] = miso_o;
    end
    half();
  endtask

  task automatic set_mode(input logic p, input logic h, input logic l);
    cpol = p; cpha = h; lsbfe = l;
    sclk = p;
    wait_cyc(6);
  endtask

  task automatic select();
    ss = 1'b0;
    wait_cyc(3);
  endtask

  task automatic deselect();
    ss = 1'b1;
    wait_cyc(6);
  endtask

  logic [7:0] got, got2;
  int rv0, ur0;

  initial begin
    PRESET_n = 1'b0;
    cpol = 0; cpha = 0; lsbfe = 0;
    ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_load = 1'b0;
    wait_cyc(3);
    PRESET_n = 1'b1;
    wait_cyc(3);
    chk("rst_miso", miso_o, 0);
    chk("rst_miso_en", miso_en_o, 0);
    chk("rst_tx_empty", tx_empty_o, 1);
    chk("rst_underrun", tx_underrun_o, 0);
    chk("rst_rx_data", rx_data_o, 8'h00);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_busy", busy_o, 0);

    // mode 0, MSB first
    set_mode(0, 0, 0);
    load(8'hA5);
    chk("m0_tx_empty_loaded", tx_empty_o, 0);
    rv0 = rv_cnt;
    ss = 1'b0;
    wait_cyc(2);
    chk("m0_busy_before_3rd_edge", busy_o, 0);
    wait_cyc(1);
    chk("m0_busy_3rd_edge", busy_o, 1);
    chk("m0_miso_en", miso_en_o, 1);
    chk("m0_tx_empty_after_start", tx_empty_o, 1);
    chk("m0_first_bit", miso_o, 1);
    xfer(8'h3C, got, 8, 0, 8'h00);
    chk("m0_rx_data", rx_data_o, 8'h3C);
    chk("m0_rx_valid_count", rv_cnt - rv0, 1);
    chk("m0_master_rx", got, 8'hA5);
    deselect();
    chk("m0_busy_idle", busy_o, 0);

    // mode 3, LSB first
    set_mode(1, 1, 1);
    load(8'h81);
    rv0 = rv_cnt;
    select();
    xfer(8'h42, got, 8, 0, 8'h00);
    chk("m3_rx_data", rx_data_o, 8'h42);
    chk("m3_rx_valid_count", rv_cnt - rv0, 1);
    chk("m3_master_rx", got, 8'h81);
    deselect();
    chk("m3_miso_idle", miso_o, 0);
    chk("m3_miso_en_idle", miso_en_o, 0);

    // mode 1, MSB first, two bytes under one select
    set_mode(0, 1, 0);
    load(8'h11);
    rv0 = rv_cnt; ur0 = ur_cnt;
    select();
    xfer(8'h5A, got, 8, 1, 8'h22);
    chk("m1_rx_byte1", rx_data_o, 8'h5A);
    xfer(8'hC3, got2, 8, 1, 8'h33);
    chk("m1_rx_byte2", rx_data_o, 8'hC3);
    chk("m1_master_b1", got, 8'h11);
    chk("m1_master_b2", got2, 8'h22);
    chk("m1_rx_valid_count", rv_cnt - rv0, 2);
    chk("m1_underruns", ur_cnt - ur0, 0);
    deselect();

    // mode 2, LSB first, two bytes under one select
    set_mode(1, 0, 1);
    load(8'h11);
    rv0 = rv_cnt; ur0 = ur_cnt;
    select();
    xfer(8'h96, got, 8, 1, 8'h22);
    chk("m2_rx_byte1", rx_data_o, 8'h96);
    xfer(8'h0F, got2, 8, 1, 8'h33);
    chk("m2_rx_byte2", rx_data_o, 8'h0F);
    chk("m2_master_b1", got, 8'h11);
    chk("m2_master_b2", got2, 8'h22);
    chk("m2_rx_valid_count", rv_cnt - rv0, 2);
    chk("m2_underruns", ur_cnt - ur0, 0);
    deselect();

    // underrun: buffer empty at select
    set_mode(0, 0, 0);
    chk("ur_tx_empty_pre", tx_empty_o, 1);
    ur0 = ur_cnt;
    select();
    xfer(8'hE7, got, 8, 1, 8'h77);
    chk("ur_count", ur_cnt - ur0, 1);
    chk("ur_master_rx", got, 8'h00);
    chk("ur_rx_data", rx_data_o, 8'hE7);
    deselect();

    // abort after 5 bits, then a full byte
    load(8'h99);
    rv0 = rv_cnt;
    select();
    xfer(8'hFF, got, 5, 0, 8'h00);
    deselect();
    chk("abort_rx_valid_count", rv_cnt - rv0, 0);
    chk("abort_rx_data_kept", rx_data_o, 8'hE7);
    load(8'h3F);
    rv0 = rv_cnt;
    select();
    xfer(8'hF0, got, 8, 0, 8'h00);
    chk("abort_next_rx_data", rx_data_o, 8'hF0);
    chk("abort_next_rx_valid", rv_cnt - rv0, 1);
    chk("abort_next_master_rx", got, 8'h3F);
    deselect();

    // asynchronous reset mid-byte
    set_mode(0, 1, 0);
    load(8'hC4);
    load(8'hD2);
    select();
    xfer(8'hAA, got, 4, 0, 8'h00);
    PRESET_n = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_miso_en", miso_en_o, 0);
    chk("arst_miso", miso_o, 0);
    chk("arst_tx_empty", tx_empty_o, 1);
    chk("arst_rx_data", rx_data_o, 8'h00);
    chk("arst_rx_valid", rx_valid_o, 0);
    chk("arst_underrun", tx_underrun_o, 0);
    ss = 1'b1;
    sclk = cpol;
    wait_cyc(3);
    PRESET_n = 1'b1;
    wait_cyc(4);
    load(8'h6B);
    rv0 = rv_cnt;
    select();
    xfer(8'h2D, got, 8, 0, 8'h00);
    chk("post_rst_rx_data", rx_data_o, 8'h2D);
    chk("post_rst_rx_valid", rv_cnt - rv0, 1);
    chk("post_rst_master_rx", got, 8'h6B);
    deselect();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
